cps_bus_slot_sched: RTL and testbench
=====================================

Name: cps_bus_slot_sched

Overview:
- Generates the 81 MHz bus timebase for the SDRAM bus:
  - ram_cyc: clock within a bank access.
  - ram_acc: bank access within a phase.
  - ram_slot: phase number within the line.
  - slot_rst: end-of-line pulse.
  - ram_ref: refresh window.
- Arbitrates each bank access between video fetch, 68000 and Z80 requesters.
- Drives the SDRAM controller, the vertical beam counter, and the CPU bus bridges.

Parameters:
- LINE_CLKS, 5148, bus clocks per line; must be a multiple of 4.
- SLOT_START, 9'h1BE, ram_slot value loaded at line start.
- REF_FIRST, 9'h1BE, first phase of the refresh window.
- REF_LAST, 9'h1C1, last phase of the refresh window.

Ports:
- bus_clk  in  1  bus clock, 81 MHz
- bus_rst  in  1  reset, asynchronous, active-high
- ram_cyc  out  4  one-hot clock within bank access
- ram_acc  out  4  one-hot bank access within phase
- ram_slot  out  9  phase counter
- slot_rst  out  1  one-clock pulse on last clock of line
- ram_ref  out  1  refresh window active
- ram_own  out  2  owner of current access: 0 idle, 1 video, 2 m68k, 3 z80
- m68k_req  in  1  68000 access request, level
- m68k_ack  out  1  68000 access done, one-clock pulse
- z80_req  in  1  Z80 access request, level
- z80_ack  out  1  Z80 access done, one-clock pulse

Behaviour:
- Reset values:
  - ram_cyc=0001, ram_acc=0001, ram_slot=SLOT_START.
  - Line clock counter=0.
  - slot_rst=0, ram_ref=1 (SLOT_START inside refresh window with defaults), ram_own=0, both acks=0.
  - Any pending or in-flight grant is dropped; reset mid-access aborts silently, with no ack.
- ram_cyc rotates left by one every clock: 0001→0010→0100→1000→0001.
- ram_acc rotates left when ram_cyc[3]=1.
- ram_slot increments, mod 512, when ram_acc[3]&ram_cyc[3]; 9'h1FF wraps to 9'h000.
- Line clock counter counts 0..LINE_CLKS-1.
- slot_rst=1 while the counter equals LINE_CLKS-1. On the following clock:
  - counter=0, ram_cyc=0001, ram_acc=0001, ram_slot=SLOT_START.
  - slot_rst has priority over the normal ram_acc/ram_slot advance.
- With defaults the line is 321 full phases (1BE..1FF, 000..0FE) plus truncated phase 0FF.
  - Phase 0FF has accesses 0..2 only.
  - slot_rst coincides with ram_acc=0100, ram_cyc=1000, ram_slot=0FF.
- ram_ref is registered: 1 whenever REF_FIRST<=ram_slot<=REF_LAST (unsigned compare), else 0. It changes in the same clock as ram_slot.
- Arbitration is decided on the clock where ram_cyc becomes 0001, from requests sampled on the preceding clock (ram_cyc[3]). ram_own is held for the 4 clocks of the access.
  - Refresh active (next-slot ram_ref=1): own=idle for all accesses.
  - acc0, acc3: own=video.
  - acc1: m68k if m68k_req and no m68k ack pending, else z80 if z80_req, else idle.
  - acc2: z80 if z80_req and no z80 ack pending, else m68k if m68k_req, else idle.
- m68k_ack / z80_ack pulse on the ram_cyc[3] clock of the owning access.
  - Requester must drop req in the clock after ack or it is served again.
  - "ack pending" masks the requester for the immediately following access, preventing double service.
- Requests deasserted mid-access: the access completes and the ack still pulses.
- Simultaneous m68k_req and z80_req: resolved by the acc1/acc2 preference above. Neither starves: each gets at least one access per phase outside refresh.
- Truncated phase 0FF: acc3 never occurs; an access in progress on acc2 completes and acks at the slot_rst clock.

Decomposition:
- Package cps_bus_pkg:
  - Owner codes OWN_IDLE/OWN_VID/OWN_M68K/OWN_Z80.
  - Default timing constants (LINE_CLKS, SLOT_START, REF_FIRST, REF_LAST).
  - One-hot reset values for ram_cyc and ram_acc.
- Sub-module cps_bus_arb: per-access owner selection and ack generation. Inputs are ram_acc, ref, the reqs and the pending flags. The top keeps the counters.

Test Plan:
- Release reset, no requests.
  - slot_rst first at clock 5147 with ram_slot=0FF, ram_acc=0100, ram_cyc=1000.
  - Next clock: ram_slot=1BE, ram_acc=0001, ram_cyc=0001.
  - slot_rst period is exactly 5148 clocks over 3 lines.
- Observe ram_ref.
  - High for ram_slot 1BE..1C1: 64 clocks from line start.
  - Low otherwise; ram_own=0 throughout that window even with both reqs held high.
- Hold m68k_req only, starting at ram_slot=1C2.
  - Grants on acc1 and acc2 alternate with the pending mask, yielding one ack per phase on acc1.
  - ram_own=2 for 4 clocks; ack on the ram_cyc[3] clock.
- Hold m68k_req and z80_req continuously for one line.
  - acc1 → 2, acc2 → 3 in every non-refresh phase.
  - 318 acks each; acc0/acc3 always 1.
- Raise z80_req during phase 0FF acc2 arbitration.
  - z80_ack is coincident with slot_rst.
  - Next access is acc0 of slot 1BE, own=0 (refresh).
- Assert bus_rst during an m68k access with ram_own=2.
  - All outputs return to reset values immediately; no m68k_ack.
  - Counting restarts from 0 on release.

Source files
------------

// File: rtl/cps_bus_slot_sched_pkg.sv
// cps_bus_pkg: owner codes, default line timing and one-hot reset values for the SDRAM bus timebase.
package cps_bus_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_M68K = 2'd2,
        OWN_Z80  = 2'd3
    } own_t;

    localparam int         DEF_LINE_CLKS  = 5148;
    localparam logic [8:0] DEF_SLOT_START = 9'h1BE;
    localparam logic [8:0] DEF_REF_FIRST  = 9'h1BE;
    localparam logic [8:0] DEF_REF_LAST   = 9'h1C1;

    localparam logic [3:0] CYC_RST = 4'b0001;
    localparam logic [3:0] ACC_RST = 4'b0001;

    function automatic logic in_ref(input logic [8:0] slot, input logic [8:0] first, input logic [8:0] last);
        return (slot >= first) && (slot <= last);
    endfunction

endpackage

// File: rtl/cps_bus_slot_sched_arb.sv
// cps_bus_arb: picks the owner of the next bank access and pulses the CPU acks on the last clock of an access.
module cps_bus_arb
    import cps_bus_pkg::*;
(
    input  logic [3:0] i_acc,
    input  logic       i_ref,
    input  logic       i_m68k_req,
    input  logic       i_z80_req,
    input  logic       i_m68k_pend,
    input  logic       i_z80_pend,
    input  logic [1:0] i_own,
    input  logic       i_cyc3,
    output logic [1:0] o_own,
    output logic       o_m68k_ack,
    output logic       o_z80_ack
);

    logic w_m68k_ok;
    logic w_z80_ok;

    assign o_m68k_ack = i_cyc3 & (i_own == OWN_M68K);
    assign o_z80_ack  = i_cyc3 & (i_own == OWN_Z80);

    // A requester acked on this clock still shows req, so it is masked for the next access.
    assign w_m68k_ok = i_m68k_req & ~i_m68k_pend;
    assign w_z80_ok  = i_z80_req & ~i_z80_pend;

    always_comb begin
        o_own = i_ref                ? OWN_IDLE :
                (i_acc[0] | i_acc[3]) ? OWN_VID  :
                i_acc[1] ? (w_m68k_ok ? OWN_M68K : w_z80_ok  ? OWN_Z80  : OWN_IDLE) :
                i_acc[2] ? (w_z80_ok  ? OWN_Z80  : w_m68k_ok ? OWN_M68K : OWN_IDLE) :
                OWN_IDLE;
    end

endmodule

// File: rtl/cps_bus_slot_sched.sv
// cps_bus_slot_sched: 81 MHz SDRAM bus timebase (clock/access/phase counters, line reset, refresh window)
// and per-access arbitration between video, 68000 and Z80.
module cps_bus_slot_sched
    import cps_bus_pkg::*;
#(
    parameter int         LINE_CLKS  = DEF_LINE_CLKS,
    parameter logic [8:0] SLOT_START = DEF_SLOT_START,
    parameter logic [8:0] REF_FIRST  = DEF_REF_FIRST,
    parameter logic [8:0] REF_LAST   = DEF_REF_LAST
) (
    input  logic       bus_clk,
    input  logic       bus_rst,
    output logic [3:0] ram_cyc,
    output logic [3:0] ram_acc,
    output logic [8:0] ram_slot,
    output logic       slot_rst,
    output logic       ram_ref,
    output logic [1:0] ram_own,
    input  logic       m68k_req,
    output logic       m68k_ack,
    input  logic       z80_req,
    output logic       z80_ack
);

    localparam int            CW       = $clog2(LINE_CLKS);
    localparam logic [CW-1:0] CNT_LAST = CW'(LINE_CLKS - 1);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cyc;
    logic [3:0]    r_acc;
    logic [8:0]    r_slot;
    logic          r_ref;
    logic [1:0]    r_own;

    logic          w_last;
    logic [3:0]    w_cyc_nxt;
    logic [3:0]    w_acc_nxt;
    logic [8:0]    w_slot_nxt;
    logic          w_ref_nxt;
    logic [1:0]    w_own_nxt;
    logic          w_m68k_ack;
    logic          w_z80_ack;

    // Line end overrides the normal rotation so every line starts on a fresh phase.
    always_comb begin
        w_last     = r_cnt == CNT_LAST;
        w_cyc_nxt  = w_last ? CYC_RST : {r_cyc[2:0], r_cyc[3]};
        w_acc_nxt  = w_last ? ACC_RST : r_cyc[3] ? {r_acc[2:0], r_acc[3]} : r_acc;
        w_slot_nxt = w_last ? SLOT_START : (r_acc[3] & r_cyc[3]) ? r_slot + 9'd1 : r_slot;
        w_ref_nxt  = in_ref(w_slot_nxt, REF_FIRST, REF_LAST);
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_cnt  <= '0;
            r_cyc  <= CYC_RST;
            r_acc  <= ACC_RST;
            r_slot <= SLOT_START;
            r_ref  <= in_ref(SLOT_START, REF_FIRST, REF_LAST);
            r_own  <= OWN_IDLE;
        end else begin
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            r_cyc  <= w_cyc_nxt;
            r_acc  <= w_acc_nxt;
            r_slot <= w_slot_nxt;
            r_ref  <= w_ref_nxt;
            if (r_cyc[3])
                r_own <= w_own_nxt;
        end
    end

    cps_bus_arb u_arb (
        .i_acc      (w_acc_nxt),
        .i_ref      (w_ref_nxt),
        .i_m68k_req (m68k_req),
        .i_z80_req  (z80_req),
        .i_m68k_pend(w_m68k_ack),
        .i_z80_pend (w_z80_ack),
        .i_own      (r_own),
        .i_cyc3     (r_cyc[3]),
        .o_own      (w_own_nxt),
        .o_m68k_ack (w_m68k_ack),
        .o_z80_ack  (w_z80_ack)
    );

    assign ram_cyc  = r_cyc;
    assign ram_acc  = r_acc;
    assign ram_slot = r_slot;
    assign slot_rst = w_last;
    assign ram_ref  = r_ref;
    assign ram_own  = r_own;
    assign m68k_ack = w_m68k_ack;
    assign z80_ack  = w_z80_ack;

endmodule

// File: tb/tb_cps_bus_slot_sched.sv
// tb_cps_bus_slot_sched: directed bench for the bus timebase and access arbitration.
module tb_cps_bus_slot_sched;

    logic       bus_clk = 1'b0;
    logic       bus_rst = 1'b1;
    logic [3:0] ram_cyc;
    logic [3:0] ram_acc;
    logic [8:0] ram_slot;
    logic       slot_rst;
    logic       ram_ref;
    logic [1:0] ram_own;
    logic       m68k_req = 1'b0;
    logic       m68k_ack;
    logic       z80_req = 1'b0;
    logic       z80_ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 bus_clk = ~bus_clk;

    cps_bus_slot_sched dut (
        .bus_clk (bus_clk),
        .bus_rst (bus_rst),
        .ram_cyc (ram_cyc),
        .ram_acc (ram_acc),
        .ram_slot(ram_slot),
        .slot_rst(slot_rst),
        .ram_ref (ram_ref),
        .ram_own (ram_own),
        .m68k_req(m68k_req),
        .m68k_ack(m68k_ack),
        .z80_req (z80_req),
        .z80_ack (z80_ack)
    );

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    // Reference timebase derived from the clock index within the line.
    function automatic logic [3:0] m_cyc(input int c);
        return 4'b0001 << (c % 4);
    endfunction
    function automatic logic [3:0] m_acc(input int c);
        return 4'b0001 << ((c / 4) % 4);
    endfunction
    function automatic logic [8:0] m_slot(input int c);
        return 9'((446 + c / 16) % 512);
    endfunction
    function automatic logic m_ref(input int c);
        int s;
        s = (446 + c / 16) % 512;
        return (s >= 446) && (s <= 449);
    endfunction

    task automatic sync_line();
        int n;
        n = 0;
        while (!slot_rst && n < 6000) begin
            tick();
            n++;
        end
        if (!slot_rst) begin
            n_cmp++;
            n_err++;
            $display("FAIL sync_line: slot_rst not seen within %0d clocks", n);
        end
        tick();
    endtask

    task automatic test_reset();
        m68k_req = 1'b1;
        z80_req  = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({ram_cyc, ram_acc} !== 8'b0001_0001) begin
            n_err++;
            $display("FAIL reset_cyc_acc: got %b want 00010001", {ram_cyc, ram_acc});
        end
        n_cmp++;
        if ({ram_slot, ram_ref} !== {9'h1BE, 1'b1}) begin
            n_err++;
            $display("FAIL reset_slot_ref: got slot %h ref %b want 1be 1", ram_slot, ram_ref);
        end
        n_cmp++;
        if ({slot_rst, ram_own, m68k_ack, z80_ack} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got rst/own/acks %b want 00000", {slot_rst, ram_own, m68k_ack, z80_ack});
        end
        m68k_req = 1'b0;
        z80_req  = 1'b0;
        @(negedge bus_clk);
        bus_rst = 1'b0;
        #1;
    endtask

    task automatic test_line_timing();
        int bad, first;
        logic [1:0] eo;
        bad   = 0;
        first = -1;
        for (int c = 0; c < 5148; c++) begin
            eo = m_ref(c) ? 2'd0 : (((c / 4) % 4 == 0) || ((c / 4) % 4 == 3)) ? 2'd1 : 2'd0;
            if ({ram_cyc, ram_acc, ram_slot, ram_ref, slot_rst, ram_own} !==
                {m_cyc(c), m_acc(c), m_slot(c), m_ref(c), c == 5147, eo}) begin
                bad++;
                if (first < 0) first = c;
            end
            if (c == 5147) begin
                n_cmp++;
                if ({slot_rst, ram_slot, ram_acc, ram_cyc} !== {1'b1, 9'h0FF, 4'b0100, 4'b1000}) begin
                    n_err++;
                    $display("FAIL line_end: got rst %b slot %h acc %b cyc %b want 1 0ff 0100 1000",
                             slot_rst, ram_slot, ram_acc, ram_cyc);
                end
            end
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL line_model: got %0d bad clocks (first %0d) want 0", bad, first);
        end
        n_cmp++;
        if ({slot_rst, ram_slot, ram_acc, ram_cyc, ram_ref} !== {1'b0, 9'h1BE, 4'b0001, 4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL line_restart: got rst %b slot %h acc %b cyc %b ref %b want 0 1be 0001 0001 1",
                     slot_rst, ram_slot, ram_acc, ram_cyc, ram_ref);
        end
    endtask

    task automatic test_period();
        int n;
        n = 0;
        while (!slot_rst && n < 6000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != 5147) begin
            n_err++;
            $display("FAIL period_first: got %0d clocks want 5147", n);
        end
        for (int l = 0; l < 3; l++) begin
            tick();
            n = 1;
            while (!slot_rst && n < 6000) begin
                tick();
                n++;
            end
            n_cmp++;
            if (n != 5148) begin
                n_err++;
                $display("FAIL period_line%0d: got %0d clocks want 5148", l, n);
            end
        end
    endtask

    task automatic test_both_reqs();
        int bad, bad_ref, nm, nz, a;
        logic [1:0] eo;
        bad = 0; bad_ref = 0; nm = 0; nz = 0;
        sync_line();
        m68k_req = 1'b1;
        z80_req  = 1'b1;
        for (int c = 0; c < 5148; c++) begin
            a  = (c / 4) % 4;
            eo = m_ref(c) ? 2'd0 : (a == 0 || a == 3) ? 2'd1 : (a == 1) ? 2'd2 : 2'd3;
            if ({ram_own, m68k_ack, z80_ack} !==
                {eo, !m_ref(c) && a == 1 && c % 4 == 3, !m_ref(c) && a == 2 && c % 4 == 3}) bad++;
            if (c < 64 && {ram_ref, ram_own, m68k_ack, z80_ack} !== 5'b10000) bad_ref++;
            if (m68k_ack === 1'b1) nm++;
            if (z80_ack === 1'b1) nz++;
            tick();
        end
        m68k_req = 1'b0;
        z80_req  = 1'b0;
        n_cmp++;
        if (bad_ref != 0) begin
            n_err++;
            $display("FAIL both_refresh_idle: got %0d bad clocks in window want 0", bad_ref);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL both_owner: got %0d bad clocks want 0", bad);
        end
        n_cmp++;
        if (nm != 318 || nz != 318) begin
            n_err++;
            $display("FAIL both_acks: got m68k %0d z80 %0d want 318 318", nm, nz);
        end
    endtask

    task automatic test_m68k_only();
        int bad, nm, a;
        logic [1:0] eo;
        bad = 0; nm = 0;
        repeat (64) tick();
        m68k_req = 1'b1;
        for (int c = 64; c < 5148; c++) begin
            a  = (c / 4) % 4;
            eo = (a == 0 || a == 3) ? 2'd1 : (a == 1) ? 2'd2 : 2'd0;
            if ({ram_own, m68k_ack, z80_ack} !== {eo, a == 1 && c % 4 == 3, 1'b0}) bad++;
            if (m68k_ack === 1'b1) nm++;
            tick();
        end
        m68k_req = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL m68k_only_owner: got %0d bad clocks want 0", bad);
        end
        n_cmp++;
        if (nm != 318) begin
            n_err++;
            $display("FAIL m68k_only_acks: got %0d want 318", nm);
        end
    endtask

    task automatic test_truncated();
        repeat (5143) tick();
        z80_req = 1'b1;
        tick();
        n_cmp++;
        if ({ram_slot, ram_acc, ram_own} !== {9'h0FF, 4'b0100, 2'd3}) begin
            n_err++;
            $display("FAIL trunc_grant: got slot %h acc %b own %0d want 0ff 0100 3", ram_slot, ram_acc, ram_own);
        end
        repeat (3) tick();
        n_cmp++;
        if ({z80_ack, slot_rst} !== 2'b11) begin
            n_err++;
            $display("FAIL trunc_ack: got z80_ack %b slot_rst %b want 1 1", z80_ack, slot_rst);
        end
        tick();
        z80_req = 1'b0;
        n_cmp++;
        if ({ram_own, ram_slot, ram_acc, z80_ack} !== {2'd0, 9'h1BE, 4'b0001, 1'b0}) begin
            n_err++;
            $display("FAIL trunc_next: got own %0d slot %h acc %b ack %b want 0 1be 0001 0",
                     ram_own, ram_slot, ram_acc, z80_ack);
        end
    endtask

    task automatic test_reset_mid();
        int n, bad;
        bad = 0;
        repeat (64) tick();
        m68k_req = 1'b1;
        n = 0;
        while (ram_own !== 2'd2 && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        if (ram_own !== 2'd2) begin
            n_err++;
            $display("FAIL rst_mid_grant: got own %0d want 2", ram_own);
        end
        #2;
        bus_rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_cyc, ram_acc, ram_slot, slot_rst, ram_ref, ram_own, m68k_ack, z80_ack} !==
            {4'b0001, 4'b0001, 9'h1BE, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_async: got cyc %b acc %b slot %h rst %b ref %b own %0d acks %b%b",
                     ram_cyc, ram_acc, ram_slot, slot_rst, ram_ref, ram_own, m68k_ack, z80_ack);
        end
        for (int i = 0; i < 4; i++) begin
            if ({m68k_ack, ram_own} !== 3'b000) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_mid_noack: got %0d clocks with ack/owner want 0", bad);
        end
        m68k_req = 1'b0;
        @(negedge bus_clk);
        bus_rst = 1'b0;
        #1;
        n = 0;
        while (!slot_rst && n < 6000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != 5147 || ram_slot !== 9'h0FF) begin
            n_err++;
            $display("FAIL rst_mid_restart: got %0d clocks slot %h want 5147 0ff", n, ram_slot);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_period();
        test_both_reqs();
        test_m68k_only();
        test_truncated();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
